// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, byte addressing and FSM encoding for the AES
// byte-substitution blocks. Byte 0 is the most significant byte of the state.
package aes_pkg;

    localparam int BYTE_W      = 8;
    localparam int STATE_W     = 128;
    localparam int STATE_BYTES = STATE_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Most significant bit of byte n; use as state[byte_msb(n) -: BYTE_W].
    function automatic int byte_msb(input int n);
        return STATE_W - 1 - BYTE_W * n;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_if.sv
// inv_sub_bytes_if: input and output valid/ready channels of the
// byte-substitution engine. The engine connects to the slave modport.
interface inv_sub_bytes_if;
    import aes_pkg::*;

    logic [STATE_W-1:0] in_state;
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] out_state;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_state, in_valid, out_ready,
        input  in_ready, out_state, out_valid
    );

    modport slave (
        input  in_state, in_valid, out_ready,
        output in_ready, out_state, out_valid
    );

endinterface

// File: rtl/inv_sbox.sv
// inv_sbox: registered FIPS-197 inverse S-box, one cycle of latency.
// With SBOX_BIDIR_EN defined this file also provides the forward sbox
// with the same interface.
module inv_sbox (
    input  logic       clk,
    input  logic [7:0] data,
    output logic [7:0] sub
);

    localparam logic [0:255][7:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Table lookup registered; pure datapath, so no reset.
    always_ff @(posedge clk) begin
        sub <= INV_TABLE[data];
    end

endmodule

`ifdef SBOX_BIDIR_EN
module sbox (
    input  logic       clk,
    input  logic [7:0] data,
    output logic [7:0] sub
);

    localparam logic [0:255][7:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup registered; pure datapath, so no reset.
    always_ff @(posedge clk) begin
        sub <= FWD_TABLE[data];
    end

endmodule
`endif

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: AES InvSubBytes over a 128-bit state, LANES bytes per cycle
// through registered inverse S-boxes, with valid/ready on both sides.
// Optional macro SBOX_BIDIR_EN adds an `inverse` input (sampled on accept)
// and forward S-boxes so the block can also perform SubBytes.
module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef SBOX_BIDIR_EN
    input  logic inverse,
`endif
    inv_sub_bytes_if.slave bus
);

    localparam int NCHUNK = STATE_BYTES / LANES;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t             fsm;
    logic [CNT_W-1:0]   cnt;
    logic [STATE_W-1:0] hold;
    logic [STATE_W-1:0] out_state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               accept;
    logic               wb_en;
    int                 wb_chunk;
    logic [BYTE_W-1:0]  lane_in  [LANES];
    logic [BYTE_W-1:0]  inv_out  [LANES];
    logic [BYTE_W-1:0]  lane_out [LANES];
`ifdef SBOX_BIDIR_EN
    logic               mode_inv;
    logic [BYTE_W-1:0]  fwd_out  [LANES];
`endif

    assign accept = in_ready_q && bus.in_valid;

    // Capture the incoming state (and mode) on the accepting edge.
    // NOTE: no reset here on purpose; the holding register is don't-care until the next accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold     <= bus.in_state;
`ifdef SBOX_BIDIR_EN
            mode_inv <= inverse;
`endif
        end
    end

    // Lane i looks up holding byte cnt*LANES+i; the result arrives one cycle later.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_in[i] = hold[byte_msb(int'(cnt) * LANES + i) -: BYTE_W];

        inv_sbox u_inv_sbox (.clk(clk), .data(lane_in[i]), .sub(inv_out[i]));
`ifdef SBOX_BIDIR_EN
        sbox u_sbox (.clk(clk), .data(lane_in[i]), .sub(fwd_out[i]));
        assign lane_out[i] = mode_inv ? inv_out[i] : fwd_out[i];
`else
        assign lane_out[i] = inv_out[i];
`endif
    end

    // Which chunk the registered S-box outputs belong to, if any, this cycle.
    // NOTE: every always_comb output is given a default first, so no latch can be inferred.
    always_comb begin
        wb_en    = 1'b0;
        wb_chunk = 0;
        case (fsm)
            RUN: begin
                wb_en    = (cnt != '0);
                wb_chunk = int'(cnt) - 1;
            end
            DRAIN: begin
                wb_en    = 1'b1;
                wb_chunk = NCHUNK - 1;
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake outputs and result write-back.
    // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        fsm        <= RUN;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(NCHUNK - 1)) begin
                        fsm <= DRAIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    fsm         <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm         <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase

            if (wb_en) begin
                for (int i = 0; i < LANES; i++) begin
                    out_state_q[byte_msb(wb_chunk * LANES + i) -: BYTE_W] <= lane_out[i];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb_inv_sub_bytes: drives three engines (LANES = 1, 4, 16) from shared
// stimulus. Expected values come from spec constants and a Galois-field
// model that derives the S-box tables arithmetically.
module tb_inv_sub_bytes;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] stim_state;
    logic         stim_valid;
    logic         stim_ready;
`ifdef SBOX_BIDIR_EN
    logic         stim_inverse;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    inv_sub_bytes_if if1();
    inv_sub_bytes_if if4();
    inv_sub_bytes_if if16();

    assign if1.in_state   = stim_state;
    assign if1.in_valid   = stim_valid;
    assign if1.out_ready  = stim_ready;
    assign if4.in_state   = stim_state;
    assign if4.in_valid   = stim_valid;
    assign if4.out_ready  = stim_ready;
    assign if16.in_state  = stim_state;
    assign if16.in_valid  = stim_valid;
    assign if16.out_ready = stim_ready;

    inv_sub_bytes #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef SBOX_BIDIR_EN
        .inverse(stim_inverse),
`endif
        .bus(if1)
    );
    inv_sub_bytes #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst),
`ifdef SBOX_BIDIR_EN
        .inverse(stim_inverse),
`endif
        .bus(if4)
    );
    inv_sub_bytes #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst),
`ifdef SBOX_BIDIR_EN
        .inverse(stim_inverse),
`endif
        .bus(if16)
    );

    // ---------------- reference model ----------------
    logic [7:0] fwd_ref [256];
    logic [7:0] inv_ref [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    // S-box = affine(multiplicative inverse in GF(2^8)); inverse table by inversion.
    task automatic build_tables();
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            fwd_ref[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_ref[fwd_ref[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        logic [7:0]   v;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            v = s[127 - 8 * n -: 8];
            r[127 - 8 * n -: 8] = inv ? inv_ref[v] : fwd_ref[v];
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present s at the next edge (all engines idle), wait 20 edges with
    // out_ready low so every engine parks in DONE, then check latency and data.
    task automatic run_one(input logic [127:0] s, input logic [127:0] exp, input string tag);
        int lat1, lat4, lat16;
        lat1 = -1; lat4 = -1; lat16 = -1;
        stim_state = s;
        stim_valid = 1'b1;
        stim_ready = 1'b0;
        tick();
        stim_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (lat1  < 0 && if1.out_valid)  lat1  = k;
            if (lat4  < 0 && if4.out_valid)  lat4  = k;
            if (lat16 < 0 && if16.out_valid) lat16 = k;
        end
        check({tag, " latency L1"},  lat1,  17);
        check({tag, " latency L4"},  lat4,  5);
        check({tag, " latency L16"}, lat16, 2);
        check({tag, " data L1"},  if1.out_state,  exp);
        check({tag, " data L4"},  if4.out_state,  exp);
        check({tag, " data L16"}, if16.out_state, exp);
    endtask

    task automatic release_all();
        stim_ready = 1'b1;
        tick();
        stim_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready L1"},   if1.in_ready,   1);
        check({tag, " in_ready L4"},   if4.in_ready,   1);
        check({tag, " in_ready L16"},  if16.in_ready,  1);
        check({tag, " out_valid L4"},  if4.out_valid,  0);
        check({tag, " out_valid L16"}, if16.out_valid, 0);
        check({tag, " out_state L1"},  if1.out_state,  0);
        check({tag, " out_state L4"},  if4.out_state,  0);
        check({tag, " out_state L16"}, if16.out_state, 0);
    endtask

    typedef struct {
        logic [127:0] in_state;
        logic [127:0] exp_state;
        string        name;
    } vec_t;

    vec_t         vecs [4];
    logic [127:0] rnd_states [8];
    logic [127:0] hold_exp;
    logic [127:0] r;
    int           issue, got, last_cyc;

    initial begin
        vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, "fips"};
        vecs[1] = '{128'h00000000000000000000000000000000, 128'h52525252525252525252525252525252, "zeros"};
        vecs[2] = '{128'h16161616161616161616161616161616, 128'hffffffffffffffffffffffffffffffff, "all16"};
        vecs[3] = '{128'h0016ed00000000000000000000000000, 128'h52ff5352525252525252525252525252, "mixed"};

        build_tables();

        rst        = 1'b1;
        stim_state = '0;
        stim_valid = 1'b0;
        stim_ready = 1'b0;
`ifdef SBOX_BIDIR_EN
        stim_inverse = 1'b1;
`endif
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Directed vectors on all three lane widths.
        for (int v = 0; v < 4; v++) begin
            run_one(vecs[v].in_state, vecs[v].exp_state, vecs[v].name);
            release_all();
        end

        // Backpressure: park in DONE for 10 cycles, try to push a new state.
        run_one(vecs[0].in_state, vecs[0].exp_state, "bp");
        hold_exp = vecs[0].exp_state;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                stim_state = 128'hdeadbeef_00112233_44556677_8899aabb;
                stim_valid = 1'b1;
            end else begin
                stim_valid = 1'b0;
            end
            tick();
            check("bp out_valid held", if4.out_valid, 1);
            check("bp out_state stable", if4.out_state, hold_exp);
            check("bp in_ready low", if4.in_ready, 0);
        end
        stim_valid = 1'b0;
        stim_ready = 1'b1;
        tick();
        check("bp release out_valid", if4.out_valid, 0);
        check("bp release in_ready", if4.in_ready, 1);
        stim_ready = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check("bp pulse ignored out_valid", if4.out_valid, 0);
        check("bp pulse ignored in_ready", if4.in_ready, 1);

        // Reset two edges into RUN aborts everything; a fresh state then completes.
        stim_state = vecs[2].in_state;
        stim_valid = 1'b1;
        tick();
        stim_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrun rst");
        r = {$urandom, $urandom, $urandom, $urandom};
        run_one(r, ref_sub(r, 1'b1), "after rst");
        release_all();

        // Back-to-back on the LANES=4 engine with in_valid and out_ready held.
        // Accept, 4 RUN cycles, DRAIN, DONE, IDLE: outputs appear every NCHUNK+3 = 7 edges.
        for (int k = 0; k < 8; k++) rnd_states[k] = {$urandom, $urandom, $urandom, $urandom};
        issue = 0;
        got = 0;
        last_cyc = -1;
        stim_ready = 1'b1;
        for (int c = 0; c < 200 && got < 8; c++) begin
            if (if4.out_valid) begin
                check($sformatf("b2b data %0d", got), if4.out_state, ref_sub(rnd_states[got], 1'b1));
                if (last_cyc >= 0) check($sformatf("b2b period %0d", got), cyc - last_cyc, 7);
                last_cyc = cyc;
                got++;
            end
            if (if4.in_ready && issue < 8) begin
                stim_state = rnd_states[issue];
                stim_valid = 1'b1;
                issue++;
            end else if (issue >= 8) begin
                stim_valid = 1'b0;
            end
            tick();
        end
        check("b2b outputs seen", got, 8);
        stim_valid = 1'b0;
        stim_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

`ifdef SBOX_BIDIR_EN
        // Forward mode, then a forward/inverse round trip.
        stim_inverse = 1'b0;
        run_one(128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, "fwd fips");
        release_all();
        r = {$urandom, $urandom, $urandom, $urandom};
        run_one(r, ref_sub(r, 1'b0), "fwd rnd");
        hold_exp = if4.out_state;
        release_all();
        stim_inverse = 1'b1;
        run_one(hold_exp, r, "round trip");
        release_all();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
